// File: rtl/hazard_pkg.sv
// Shared encodings and helpers for the pipeline hazard controller.
package hazard_pkg;

  // ALU operand forward select encodings
  typedef enum logic [1:0] {
    FWD_NONE = 2'b00,
    FWD_WB   = 2'b01,
    FWD_MEM  = 2'b10
  } fwd_sel_e;

  localparam logic [4:0]  REG_ZERO  = 5'd0;
  localparam int unsigned MDU_CNT_W = 4;

  // True when a producer register is real (not r0) and matches the consumer.
  function automatic logic reg_match(input logic [4:0] producer, input logic [4:0] consumer);
    return (producer != REG_ZERO) && (producer == consumer);
  endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// Pipeline-side bundle of the hazard controller: stage register ids and
// controls in, stall/flush/forward selects out.
interface hazard_unit_if #(
  parameter int unsigned STALL_CNT_W = 16
);
  logic [4:0]             RsD, RtD, RsE, RtE;
  logic [4:0]             WriteRegE, WriteRegM, WriteRegW;
  logic                   RegWriteE, RegWriteM, RegWriteW;
  logic                   MemtoRegE, MemtoRegM;
  logic                   BranchD, MduStartE, MduReadD;
  logic                   StallF, StallD, FlushE;
  logic [1:0]             ForwardAE, ForwardBE;
  logic                   ForwardAD, ForwardBD;
  logic                   MduBusy;
  logic [STALL_CNT_W-1:0] StallCount;

  modport master (
    output RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW,
           RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM,
           BranchD, MduStartE, MduReadD,
    input  StallF, StallD, FlushE, ForwardAE, ForwardBE,
           ForwardAD, ForwardBD, MduBusy, StallCount
  );

  modport slave (
    input  RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW,
           RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM,
           BranchD, MduStartE, MduReadD,
    output StallF, StallD, FlushE, ForwardAE, ForwardBE,
           ForwardAD, ForwardBD, MduBusy, StallCount
  );
endinterface

// File: rtl/hazard_unit_mdu_busy_tracker.sv
// Tracks an in-flight multiply/divide: a start loads the remaining-cycle
// counter (restart reloads, never accumulates); MduBusy is registered.
module mdu_busy_tracker
  import hazard_pkg::*;
#(
  parameter int unsigned MDU_LATENCY = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic MduStartE,
  output logic MduBusy
);

  logic [MDU_CNT_W-1:0] cnt_q, cnt_d;
  logic                 busy_q, busy_d;

  // Next-state: reload on start, otherwise count down to zero
  always_comb begin
    cnt_d = cnt_q;
    if (MduStartE) begin
      cnt_d = MDU_CNT_W'(MDU_LATENCY - 1);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - MDU_CNT_W'(1);
    end
    busy_d = (cnt_d != '0);
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  assign MduBusy = busy_q;

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard controller: stalls, E-stage flush, operand forwarding,
// MDU busy tracking and a saturating stall-cycle counter.
// Optional macro HAZARD_BRANCH_FWD_EN: branches resolve in D, enabling
// D-stage forwarding from M and the branch-operand stall.
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int unsigned MDU_LATENCY = 4,
  parameter int unsigned STALL_CNT_W = 16
) (
  input  logic          clk,
  input  logic          rst,
  hazard_unit_if.slave  hif
);

  fwd_sel_e               fwd_ae, fwd_be;
  logic                   fwd_ad, fwd_bd;
  logic                   lwstall, mdustall, branchstall, stall;
  logic                   mdu_busy;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  mdu_busy_tracker #(
    .MDU_LATENCY (MDU_LATENCY)
  ) u_mdu (
    .clk       (clk),
    .rst       (rst),
    .MduStartE (hif.MduStartE),
    .MduBusy   (mdu_busy)
  );

  // Hazard detection and forward selection; M has priority over W
  always_comb begin
    fwd_ae = FWD_NONE;
    if (hif.RegWriteM && reg_match(hif.WriteRegM, hif.RsE))      fwd_ae = FWD_MEM;
    else if (hif.RegWriteW && reg_match(hif.WriteRegW, hif.RsE)) fwd_ae = FWD_WB;

    fwd_be = FWD_NONE;
    if (hif.RegWriteM && reg_match(hif.WriteRegM, hif.RtE))      fwd_be = FWD_MEM;
    else if (hif.RegWriteW && reg_match(hif.WriteRegW, hif.RtE)) fwd_be = FWD_WB;

    lwstall  = hif.MemtoRegE &&
               (reg_match(hif.RtE, hif.RsD) || reg_match(hif.RtE, hif.RtD));
    mdustall = hif.MduReadD && (mdu_busy || hif.MduStartE);

`ifdef HAZARD_BRANCH_FWD_EN
    fwd_ad      = hif.RegWriteM && reg_match(hif.WriteRegM, hif.RsD);
    fwd_bd      = hif.RegWriteM && reg_match(hif.WriteRegM, hif.RtD);
    branchstall = hif.BranchD &&
                  ((hif.RegWriteE &&
                    (reg_match(hif.WriteRegE, hif.RsD) || reg_match(hif.WriteRegE, hif.RtD))) ||
                   (hif.MemtoRegM &&
                    (reg_match(hif.WriteRegM, hif.RsD) || reg_match(hif.WriteRegM, hif.RtD))));
`else
    fwd_ad      = 1'b0;
    fwd_bd      = 1'b0;
    branchstall = 1'b0;
`endif

    stall = lwstall || mdustall || branchstall;
  end

  // Saturating stall-cycle counter next value
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
    end
  end

  // Stall counter register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // During reset the E stage is held flushed and no stall/forward is issued
  assign hif.StallF     = rst ? 1'b0 : stall;
  assign hif.StallD     = rst ? 1'b0 : stall;
  assign hif.FlushE     = rst ? 1'b1 : stall;
  assign hif.ForwardAE  = rst ? FWD_NONE : fwd_ae;
  assign hif.ForwardBE  = rst ? FWD_NONE : fwd_be;
  assign hif.ForwardAD  = rst ? 1'b0 : fwd_ad;
  assign hif.ForwardBD  = rst ? 1'b0 : fwd_bd;
  assign hif.MduBusy    = mdu_busy;
  assign hif.StallCount = stall_cnt_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit (MDU_LATENCY=4, STALL_CNT_W=4).
module tb_hazard_unit;

`ifdef HAZARD_BRANCH_FWD_EN
  localparam bit BR = 1'b1;
`else
  localparam bit BR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  hazard_unit_if #(.STALL_CNT_W(4)) hif ();

  hazard_unit #(
    .MDU_LATENCY (4),
    .STALL_CNT_W (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .hif (hif.slave)
  );

  typedef struct packed {
    logic [4:0] rsd, rtd, rse, rte, wre, wrm, wrw;
    logic       rwe, rwm, rww, mre, mrm, br;
    logic       st;
    logic [1:0] fae, fbe;
    logic       fad, fbd;
  } vec_t;

  typedef struct packed {
    logic       sf, sd, fe;
    logic [1:0] fae, fbe;
    logic       fad, fbd, busy;
    logic [3:0] sc;
  } exp_t;

  int   tests = 0;
  int   fails = 0;
  exp_t sbq[$];
  logic [3:0] exp_sc = 4'h0;
  vec_t vt[16];

  task automatic drive_idle();
    hif.RsD = '0; hif.RtD = '0; hif.RsE = '0; hif.RtE = '0;
    hif.WriteRegE = '0; hif.WriteRegM = '0; hif.WriteRegW = '0;
    hif.RegWriteE = 1'b0; hif.RegWriteM = 1'b0; hif.RegWriteW = 1'b0;
    hif.MemtoRegE = 1'b0; hif.MemtoRegM = 1'b0;
    hif.BranchD = 1'b0; hif.MduStartE = 1'b0; hif.MduReadD = 1'b0;
  endtask

  task automatic drive_load_use();
    hif.MemtoRegE = 1'b1; hif.RtE = 5'd8; hif.RsD = 5'd8;
  endtask

  // Push the expectation, compare at the falling edge, advance the count model
  task automatic check(input string nm, input logic st, input logic [1:0] fae,
                       input logic [1:0] fbe, input logic fad, input logic fbd,
                       input logic busy);
    exp_t e, got, want;
    e.sf   = rst ? 1'b0 : st;
    e.sd   = rst ? 1'b0 : st;
    e.fe   = rst ? 1'b1 : st;
    e.fae  = rst ? 2'b00 : fae;
    e.fbe  = rst ? 2'b00 : fbe;
    e.fad  = rst ? 1'b0 : fad;
    e.fbd  = rst ? 1'b0 : fbd;
    e.busy = busy;
    e.sc   = exp_sc;
    sbq.push_back(e);
    @(negedge clk);
    got.sf = hif.StallF;     got.sd = hif.StallD;     got.fe = hif.FlushE;
    got.fae = hif.ForwardAE; got.fbe = hif.ForwardBE;
    got.fad = hif.ForwardAD; got.fbd = hif.ForwardBD;
    got.busy = hif.MduBusy;  got.sc = hif.StallCount;
    want = sbq.pop_front();
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got sF=%b sD=%b fE=%b fAE=%b fBE=%b fAD=%b fBD=%b busy=%b cnt=%h, expected sF=%b sD=%b fE=%b fAE=%b fBE=%b fAD=%b fBD=%b busy=%b cnt=%h",
               nm, got.sf, got.sd, got.fe, got.fae, got.fbe, got.fad, got.fbd, got.busy, got.sc,
               want.sf, want.sd, want.fe, want.fae, want.fbe, want.fad, want.fbd, want.busy, want.sc);
    end
    if (rst) exp_sc = 4'h0;
    else if (st && exp_sc != 4'hF) exp_sc = exp_sc + 4'h1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vt[0]  = '{rse:5'd5, rwm:1'b1, wrm:5'd5, rww:1'b1, wrw:5'd5, fae:2'b10, default:'0};
    vt[1]  = '{rse:5'd5, wrm:5'd5, rww:1'b1, wrw:5'd5, fae:2'b01, default:'0};
    vt[2]  = '{rwm:1'b1, rww:1'b1, default:'0};
    vt[3]  = '{rse:5'd9, rte:5'd7, rwm:1'b1, wrm:5'd7, rww:1'b1, wrw:5'd9,
               fae:2'b01, fbe:2'b10, default:'0};
    vt[4]  = '{rte:5'd7, wrm:5'd7, default:'0};
    vt[5]  = '{mre:1'b1, rte:5'd8, rsd:5'd8, st:1'b1, default:'0};
    vt[6]  = '{rte:5'd8, rsd:5'd8, default:'0};
    vt[7]  = '{mre:1'b1, rte:5'd4, rtd:5'd4, st:1'b1, default:'0};
    vt[8]  = '{mre:1'b1, default:'0};
    vt[9]  = '{mre:1'b1, rte:5'd6, rsd:5'd7, rtd:5'd9, default:'0};
    vt[10] = '{br:1'b1, rsd:5'd3, rwe:1'b1, wre:5'd3, st:BR, default:'0};
    vt[11] = '{br:1'b1, rsd:5'd3, rwm:1'b1, wrm:5'd3, fad:BR, default:'0};
    vt[12] = '{br:1'b1, rtd:5'd10, mrm:1'b1, rwm:1'b1, wrm:5'd10, st:BR, fbd:BR, default:'0};
    vt[13] = '{rsd:5'd3, rwe:1'b1, wre:5'd3, default:'0};
    vt[14] = '{br:1'b1, rwe:1'b1, default:'0};
    vt[15] = '{br:1'b1, rsd:5'd3, rtd:5'd3, rwm:1'b1, wrm:5'd3, fad:BR, fbd:BR, default:'0};

    rst = 1'b1;
    drive_idle();
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      hif.RsD = vt[i].rsd; hif.RtD = vt[i].rtd; hif.RsE = vt[i].rse; hif.RtE = vt[i].rte;
      hif.WriteRegE = vt[i].wre; hif.WriteRegM = vt[i].wrm; hif.WriteRegW = vt[i].wrw;
      hif.RegWriteE = vt[i].rwe; hif.RegWriteM = vt[i].rwm; hif.RegWriteW = vt[i].rww;
      hif.MemtoRegE = vt[i].mre; hif.MemtoRegM = vt[i].mrm; hif.BranchD = vt[i].br;
      hif.MduStartE = 1'b0; hif.MduReadD = 1'b0;
      check($sformatf("vec%0d", i), vt[i].st, vt[i].fae, vt[i].fbe, vt[i].fad, vt[i].fbd, 1'b0);
    end

    // MDU start with reader waiting: stall t..t+3, busy t+1..t+3
    drive_idle();
    hif.MduStartE = 1'b1; hif.MduReadD = 1'b1;
    check("mdu_t0", 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    hif.MduStartE = 1'b0;
    for (int i = 1; i <= 3; i++) check($sformatf("mdu_t%0d", i), 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1);
    check("mdu_t4", 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);

    // Restart at t+2 reloads the counter
    drive_idle();
    hif.MduStartE = 1'b1;
    check("restart_t0", 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    hif.MduStartE = 1'b0;
    check("restart_t1", 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1);
    hif.MduStartE = 1'b1;
    check("restart_t2", 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1);
    hif.MduStartE = 1'b0;
    for (int i = 3; i <= 5; i++) check($sformatf("restart_t%0d", i), 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1);
    check("restart_t6", 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);

    // Load-use coinciding with MDU start/read: one stall per cycle
    drive_idle();
    drive_load_use();
    hif.MduStartE = 1'b1; hif.MduReadD = 1'b1;
    check("both_t0", 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    drive_idle();
    hif.MduReadD = 1'b1;
    for (int i = 1; i <= 3; i++) check($sformatf("both_t%0d", i), 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1);
    check("both_t4", 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);

    // Reset while MDU busy abandons the operation
    drive_idle();
    hif.MduStartE = 1'b1; hif.MduReadD = 1'b1;
    check("rstmid_t0", 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    hif.MduStartE = 1'b0;
    rst = 1'b1;
    check("rstmid_t1", 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1);
    check("rstmid_t2", 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    check("rstmid_t3", 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    check("rstmid_t4", 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);

    // Counter saturates at all-ones
    drive_idle();
    drive_load_use();
    for (int i = 0; i < 20; i++) check($sformatf("sat%0d", i), 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    drive_idle();
    check("sat_final", 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
